// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ID-stage control logic of the pipelined MIPS core.
package cpu_ctrl_pkg;

  // Register file index width (32 architectural registers).
  localparam int REG_W = 5;

  // Instruction word used when IF/ID or ID/EX is cleared (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Branch/jump sequencing states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } bh_state_t;

  // True when destination r feeds one of the ID-stage branch operands.
  // rt only counts for compare-type branches; $0 is hardwired and never a dependency.
  function automatic logic src_match(
    input logic [REG_W-1:0] r,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             rt_used
  );
    return (r != '0) && ((r == rs) || (rt_used && (r == rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count register: async clear on reset, sync clear, increment until saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/jump sequencer: stalls on unresolved branch operands,
// gates the PC redirect and squashes wrong-path fetches after it.
module branch_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DELAY_SLOT  = 0,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             pc_src_in,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pc_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  // Extra squash cycles spent in FLUSH after the redirect cycle itself.
  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_DEPTH - 1);
  localparam bit         FLUSH_STATE = (FLUSH_DEPTH > 1);
  localparam bit         SQUASH_SLOT = (DELAY_SLOT == 0);

  bh_state_t  r_state;
  bh_state_t  w_next_state;
  logic [2:0] r_fcnt;
  logic [2:0] w_fcnt_next;

  logic w_ctl;
  logic w_rt_used;
  logic w_hz;
  logic w_taken;
  logic w_stall_inc;
  logic w_flush_inc;

  // Hazard detection. Loads are only visible as writers once they reach MEM,
  // but ex_regwrite already covers a load sitting in EX, so a load stalls twice.
  assign w_ctl     = id_branch | id_jr;
  assign w_rt_used = id_use_rt & id_branch;
  assign w_hz      = w_ctl &
                     ((ex_regwrite & src_match(ex_rd,  id_rs, id_rt, w_rt_used)) |
                      (mem_memread & src_match(mem_rd, id_rs, id_rt, w_rt_used)));
  // A redirect request; only honoured once the operands are clean.
  assign w_taken   = pc_src_in | id_jump;

  // State and squash-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_fcnt  <= w_fcnt_next;
    end
  end

  // Next-state and Mealy outputs; freeze overrides everything and holds all state.
  always_comb begin
    w_next_state = r_state;
    w_fcnt_next  = r_fcnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    pc_sel       = 1'b0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;

    if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      unique case (r_state)
        FLUSH: begin
          // ID holds wrong-path instructions here, so branch inputs are ignored.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          w_flush_inc = 1'b1;
          if (r_fcnt <= 3'd1) begin
            w_next_state = RUN;
            w_fcnt_next  = '0;
          end else begin
            w_fcnt_next = r_fcnt - 3'd1;
          end
        end
        default: begin
          // RUN and STALL share one decision; STALL only records that we are waiting.
          if (w_hz) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            w_stall_inc  = 1'b1;
            w_next_state = STALL;
          end else if (w_taken) begin
            pc_sel = 1'b1;
            if (SQUASH_SLOT) begin
              ifid_flush  = 1'b1;
              w_flush_inc = 1'b1;
            end
            if (FLUSH_STATE) begin
              w_next_state = FLUSH;
              w_fcnt_next  = FLUSH_LOAD;
            end else begin
              w_next_state = RUN;
            end
          end else begin
            w_next_state = RUN;
          end
        end
      endcase
    end

    // While reset is held the pipeline free-runs with no redirect or squash.
    if (!rst_n) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pc_sel      = 1'b0;
      w_stall_inc = 1'b0;
      w_flush_inc = 1'b0;
    end
  end

  assign dbg_state = r_state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .clr   (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: three configurations share one input stream,
// each checked every cycle against a behavioural model, plus literal spot checks.
module tb_branch_hazard_ctrl;

  // Output vector bit positions: {pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel}
  localparam int B_PCW = 4;
  localparam int B_IFW = 3;
  localparam int B_FL  = 2;
  localparam int B_BUB = 1;
  localparam int B_SEL = 0;

  logic       clk;
  logic       rst_n;
  logic       freeze;
  logic       id_branch, id_jump, id_jr, id_use_rt;
  logic [4:0] id_rs, id_rt;
  logic       ex_regwrite, ex_memread;
  logic [4:0] ex_rd;
  logic       mem_memread;
  logic [4:0] mem_rd;
  logic       pc_src_in;

  logic [4:0]  act_v  [3];
  logic [15:0] act_s  [3];
  logic [15:0] act_f  [3];
  logic [1:0]  act_st [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per configuration: remaining squash cycles and counter values.
  int m_left [3];
  int m_sc   [3];
  int m_fc   [3];

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Configurations: 0 = DS0/FD1/16b, 1 = DS0/FD3/4b, 2 = DS1/FD1/16b
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DS = (g == 2) ? 1 : 0;
    localparam int FD = (g == 1) ? 3 : 1;
    localparam int CW = (g == 1) ? 4 : 16;
    logic          pcw, ifw, fl, bub, sel;
    logic [CW-1:0] sc, fc;
    logic [1:0]    st;
    branch_hazard_ctrl #(.DELAY_SLOT(DS), .FLUSH_DEPTH(FD), .CNT_W(CW)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .freeze      (freeze),
      .id_branch   (id_branch),
      .id_jump     (id_jump),
      .id_jr       (id_jr),
      .id_use_rt   (id_use_rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .ex_regwrite (ex_regwrite),
      .ex_memread  (ex_memread),
      .ex_rd       (ex_rd),
      .mem_memread (mem_memread),
      .mem_rd      (mem_rd),
      .pc_src_in   (pc_src_in),
      .pc_write    (pcw),
      .ifid_write  (ifw),
      .ifid_flush  (fl),
      .idex_bubble (bub),
      .pc_sel      (sel),
      .stall_cnt   (sc),
      .flush_cnt   (fc),
      .dbg_state   (st)
    );
    assign act_v[g]  = {pcw, ifw, fl, bub, sel};
    assign act_s[g]  = 16'(sc);
    assign act_f[g]  = 16'(fc);
    assign act_st[g] = st;
  end

  function automatic int ds_of(int k);  return (k == 2) ? 1 : 0;  endfunction
  function automatic int fd_of(int k);  return (k == 1) ? 3 : 1;  endfunction
  function automatic int max_of(int k); return (k == 1) ? 15 : 65535; endfunction

  function automatic bit hit(logic [4:0] r);
    return (r != 0) && ((r == id_rs) || (id_use_rt && id_branch && (r == id_rt)));
  endfunction

  function automatic bit model_hz();
    return (id_branch || id_jr) && ((ex_regwrite && hit(ex_rd)) || (mem_memread && hit(mem_rd)));
  endfunction

  task automatic cmp(string nm, int k, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[cfg%0d] t=%0t got %0h want %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic lit(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Scoreboard: compare every configuration against the model on each falling edge,
  // then advance the model to what the next rising edge must produce.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [4:0] ev;
      bit sinc, finc;
      sinc = 0;
      finc = 0;
      if (!rst_n) begin
        m_left[k] = 0;
        m_sc[k]   = 0;
        m_fc[k]   = 0;
        ev = 5'b11000;
      end else if (freeze) begin
        ev = 5'b00000;
      end else if (m_left[k] > 0) begin
        ev = 5'b11110;
        finc = 1;
        m_left[k] = m_left[k] - 1;
      end else if (model_hz()) begin
        ev = 5'b00010;
        sinc = 1;
      end else if (pc_src_in || id_jump) begin
        ev = {1'b1, 1'b1, (ds_of(k) == 0), 1'b0, 1'b1};
        finc = (ds_of(k) == 0);
        m_left[k] = fd_of(k) - 1;
      end else begin
        ev = 5'b11000;
      end
      cmp("outputs",   k, int'(act_v[k]), int'(ev));
      cmp("stall_cnt", k, int'(act_s[k]), m_sc[k]);
      cmp("flush_cnt", k, int'(act_f[k]), m_fc[k]);
      if (sinc && m_sc[k] < max_of(k)) m_sc[k] = m_sc[k] + 1;
      if (finc && m_fc[k] < max_of(k)) m_fc[k] = m_fc[k] + 1;
    end
  end

  // Driver tasks
  task automatic set_idle();
    freeze = 0; id_branch = 0; id_jump = 0; id_jr = 0; id_use_rt = 0;
    id_rs = 0; id_rt = 0; ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_memread = 0; mem_rd = 0; pc_src_in = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    set_idle();
    step();
    rst_n = 1;
  endtask

  task automatic alu_hazard();
    id_branch = 1; id_use_rt = 1; id_rs = 3; id_rt = 4;
    ex_regwrite = 1; ex_rd = 4; pc_src_in = 0;
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    step();
    step();
    rst_n = 1;

    // ALU hazard on beq $3,$4, then taken
    do_reset();
    alu_hazard();
    peek();
    lit("alu_stall_pcw", int'(act_v[0][B_PCW]), 0);
    lit("alu_stall_bub", int'(act_v[0][B_BUB]), 1);
    step();
    ex_regwrite = 0; pc_src_in = 1;
    peek();
    lit("alu_redirect_sel",   int'(act_v[0][B_SEL]), 1);
    lit("alu_redirect_flush", int'(act_v[0][B_FL]),  1);
    lit("ds_redirect_sel",    int'(act_v[2][B_SEL]), 1);
    lit("ds_redirect_flush",  int'(act_v[2][B_FL]),  0);
    step();
    set_idle();
    repeat (3) step();
    peek();
    lit("alu_stall_cnt", int'(act_s[0]), 1);
    lit("alu_flush_cnt", int'(act_f[0]), 1);
    lit("fd3_flush_cnt", int'(act_f[1]), 3);
    lit("ds_flush_cnt",  int'(act_f[2]), 0);
    step();

    // Load hazard on bne $5,$0: two stall cycles, $0 never matches
    do_reset();
    id_branch = 1; id_use_rt = 1; id_rs = 5; id_rt = 0;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5;
    step();
    ex_regwrite = 0; ex_memread = 0; mem_memread = 1; mem_rd = 5;
    step();
    mem_memread = 0; mem_rd = 0;
    step();
    id_rs = 6; ex_regwrite = 1; ex_rd = 0;
    peek();
    lit("rd0_no_stall", int'(act_v[0][B_PCW]), 1);
    step();
    set_idle();
    peek();
    lit("load_stall_cnt", int'(act_s[0]), 2);
    step();

    // jr $31 behind a load in MEM, then j with ex_rd == rs
    do_reset();
    id_jr = 1; id_rs = 31; mem_memread = 1; mem_rd = 31;
    peek();
    lit("jr_stall_pcw", int'(act_v[0][B_PCW]), 0);
    step();
    mem_memread = 0; pc_src_in = 1;
    peek();
    lit("jr_redirect_sel", int'(act_v[0][B_SEL]), 1);
    step();
    set_idle();
    id_jump = 1; id_rs = 7; ex_regwrite = 1; ex_rd = 7;
    peek();
    lit("j_no_stall_sel", int'(act_v[0][B_SEL]), 1);
    lit("j_no_stall_pcw", int'(act_v[0][B_PCW]), 1);
    step();
    set_idle();
    peek();
    lit("jr_stall_cnt", int'(act_s[0]), 1);
    step();

    // freeze during a stall and during the redirect cycle
    do_reset();
    alu_hazard();
    step();
    freeze = 1;
    peek();
    lit("frz_pcw", int'(act_v[0][B_PCW]), 0);
    lit("frz_ifw", int'(act_v[0][B_IFW]), 0);
    lit("frz_bub", int'(act_v[0][B_BUB]), 0);
    step();
    step();
    freeze = 0;
    step();
    ex_regwrite = 0; pc_src_in = 1; freeze = 1;
    peek();
    lit("frz_redirect_sel", int'(act_v[0][B_SEL]), 0);
    step();
    freeze = 0;
    step();
    set_idle();
    step();
    peek();
    lit("frz_stall_cnt", int'(act_s[0]), 2);
    lit("frz_flush_cnt", int'(act_f[0]), 1);
    step();

    // 20 hazard cycles: the 4-bit counter saturates at 15
    do_reset();
    alu_hazard();
    repeat (20) step();
    set_idle();
    peek();
    lit("sat4_stall_cnt",  int'(act_s[1]), 15);
    lit("sat16_stall_cnt", int'(act_s[0]), 20);
    step();

    // Reset asserted while the FLUSH_DEPTH=3 configuration is squashing
    do_reset();
    id_jump = 1;
    step();
    set_idle();
    #2;
    rst_n = 0;
    #1;
    lit("rst_mid_flush_outputs", int'(act_v[1]), 5'b11000);
    lit("rst_mid_flush_stall",   int'(act_s[1]), 0);
    lit("rst_mid_flush_flush",   int'(act_f[1]), 0);
    step();
    rst_n = 1;
    peek();
    lit("rst_release_state", int'(act_st[1]), 0);
    lit("rst_release_flush", int'(act_v[1][B_FL]), 0);
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int kind;
      set_idle();
      rst_n = ($urandom_range(0, 199) != 0);
      freeze = ($urandom_range(0, 7) == 0);
      kind = $urandom_range(0, 3);
      id_branch = (kind == 1);
      id_jr     = (kind == 2);
      id_jump   = (kind == 3);
      id_use_rt = $urandom_range(0, 1);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_regwrite = $urandom_range(0, 1);
      ex_memread  = ex_regwrite && ($urandom_range(0, 2) == 0);
      ex_rd = 5'($urandom_range(0, 3));
      mem_memread = ($urandom_range(0, 2) == 0);
      mem_rd = 5'($urandom_range(0, 3));
      pc_src_in = $urandom_range(0, 1);
      step();
    end
    rst_n = 1;
    set_idle();
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Sequences the ID-stage branch/jump resolution logic of the pipelined MIPS core.
- Detects operand hazards on branch and jump-register sources, and stalls PC and IF/ID until the operands are valid.
- Gates the PC redirect, and flushes wrong-path fetches after a taken branch or jump.
- Keeps saturating stall and flush counters for performance debugging.

Parameters:
- DELAY_SLOT, 0: 1 = MIPS delay slot; the instruction after the branch is never flushed.
- FLUSH_DEPTH, 1: number of wrong-path fetch cycles to squash after a redirect (1..7).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- freeze  in  1  global pipeline hold (memory wait); highest priority.
- id_branch  in  1  ID instruction is a conditional branch.
- id_jump  in  1  ID instruction is j/jal.
- id_jr  in  1  ID instruction is jr/jalr (reads rs).
- id_use_rt  in  1  branch compares rt (beq/bne).
- id_rs  in  5  ID source register rs.
- id_rt  in  5  ID source register rt.
- ex_regwrite  in  1  EX instruction writes the register file.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- mem_memread  in  1  MEM instruction is a load.
- mem_rd  in  5  MEM destination register.
- pc_src_in  in  1  raw taken/jump decision from the branch resolution unit.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to a NOP at the next edge.
- idex_bubble  out  1  insert a NOP into ID/EX.
- pc_sel  out  1  select the branch/jump target for the next PC.
- stall_cnt  out  CNT_W  total hazard-stall cycles, saturating.
- flush_cnt  out  CNT_W  total flushed fetch slots, saturating.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - State goes to RUN; the flush counter and both performance counters clear.
  - Outputs during reset: pc_write = 1, ifid_write = 1, ifid_flush = 0, idex_bubble = 0, pc_sel = 0.
- Operand and hazard definitions:
  - ctl = id_branch | id_jr.
  - A source matches reg r when (r == id_rs) or (id_use_rt & id_branch & r == id_rt), and r != 0. Register $0 never matches.
  - hz = ctl & ((ex_regwrite & match(ex_rd)) | (mem_memread & match(mem_rd))).
  - A load in EX therefore stalls 2 cycles: once while in EX, once while in MEM. An ALU op in EX stalls 1 cycle.
  - j/jal never stall.
- States are RUN, STALL and FLUSH. Outputs are Mealy, computed combinationally from state and inputs.
- freeze = 1:
  - pc_write = 0, ifid_write = 0; all other outputs are 0.
  - State, the flush counter and both performance counters hold.
  - The decision is re-evaluated after freeze drops.
- RUN, hz = 1:
  - pc_write = 0, ifid_write = 0, idex_bubble = 1, pc_sel = 0; stall_cnt increments.
  - Next state is STALL.
- RUN, hz = 0 and (pc_src_in | id_jump):
  - pc_sel = 1, pc_write = 1.
  - If DELAY_SLOT = 0: ifid_flush = 1 and flush_cnt increments.
  - If FLUSH_DEPTH > 1: next state is FLUSH with the flush counter loaded to FLUSH_DEPTH-1. Otherwise stay in RUN.
- RUN otherwise: normal advance; all enables 1, all other outputs 0.
- STALL:
  - Re-evaluates hz every cycle. While hz = 1, behave as the RUN stall case and stay in STALL.
  - When hz = 0, behave exactly as RUN with hz = 0 in the same cycle (redirect or advance), then leave STALL by the same transitions as RUN.
- FLUSH:
  - ifid_flush = 1, idex_bubble = 1, pc_sel = 0, pc_write = 1; flush_cnt increments.
  - The flush counter decrements; return to RUN when it reaches 1.
  - ID branch inputs are ignored in this state, since ID holds wrong-path instructions.
- The pc_src_in decision is honoured only when hz = 0, so a stale comparison never redirects.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-STALL or mid-FLUSH aborts immediately; nothing resumes after reset.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state enum: RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2;
  - the register index width (5);
  - the NOP encoding constant used by the IF/ID and ID/EX clears.
- Sub-module sat_counter (parameter W, inputs inc/clr), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset: rst_n low mid-FLUSH with FLUSH_DEPTH = 3 -> outputs immediately 1/1/0/0/0, counters 0; the first cycle after release is in RUN.
- ALU hazard: beq $3,$4 in ID, EX writes $4 (alu) -> exactly 1 stall cycle (pc_write = 0, idex_bubble = 1), then pc_src_in = 1 -> pc_sel = 1, ifid_flush = 1; stall_cnt = 1, flush_cnt = 1.
- Load hazard: bne $5,$0 with lw $5 in EX -> 2 stall cycles, stall_cnt = 2; $0 in rt is ignored; ex_rd = 0 with ex_regwrite = 1 -> no stall.
- jr $31 with lw $31 in MEM -> 1 stall cycle; j with ex_rd = rs -> no stall, immediate pc_sel = 1.
- DELAY_SLOT = 1, taken beq -> pc_sel = 1, ifid_flush = 0, flush_cnt unchanged. FLUSH_DEPTH = 3, taken -> ifid_flush high 3 consecutive cycles, flush_cnt = 3.
- freeze = 1 during a STALL and during a redirect cycle -> all enables 0, no counter increment; after release, sequence completes identically. CNT_W = 4 with 20 stalls -> stall_cnt = 15.
